// File: rtl/shared_resource_pkg.sv
// Shared definitions for the shared-resource arbiter: operation encodings
// and the supported parameter ranges.
package shared_resource_pkg;

    typedef enum logic [1:0] {
        OP_DBL  = 2'b00,
        OP_PASS = 2'b01,
        OP_SAT  = 2'b10,
        OP_RSVD = 2'b11
    } op_mode_e;

    localparam int NUM_CH_MIN = 2;
    localparam int NUM_CH_MAX = 8;
    localparam int DATA_W_MIN = 8;
    localparam int DATA_W_MAX = 64;
    localparam int LAT_MIN    = 1;
    localparam int LAT_MAX    = 4;

endpackage

// File: rtl/shared_resource_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among active requests, search starting
// at the rotating pointer, which moves past the winner on every grant.
module rr_arbiter
    import shared_resource_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        // Wrap-around search split in two passes: indices at/above the pointer, then below it.
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= 32'(ptr_q))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i < 32'(ptr_q))) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
                ptr_d      = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        if (reset) begin
            grant_o = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_resource_arb.sv
// Multi-channel front end to a single operation unit: round-robin grant,
// result computed at grant time, carried through a fixed-latency pipeline.
module shared_resource_arb
    import shared_resource_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    input  logic [1:0]               op_mode,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_ovf
);

    logic [NUM_CH-1:0] grant;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] res_d;
    logic              ovf_d;

    logic [LAT-1:0][NUM_CH-1:0] tag_q;
    logic [LAT-1:0][DATA_W-1:0] data_q;
    logic [LAT-1:0]             ovf_q;

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req_valid),
        .grant_o(grant)
    );

    assign req_ready = grant;

    always_comb begin
        operand = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                operand = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        res_d = operand;
        ovf_d = 1'b0;
        case (op_mode_e'(op_mode))
            OP_DBL: begin
                res_d = operand << 1;
                ovf_d = operand[DATA_W-1];
            end
            OP_SAT: begin
                res_d = operand[DATA_W-1] ? '1 : (operand << 1);
                ovf_d = operand[DATA_W-1];
            end
            OP_PASS, OP_RSVD: begin
                res_d = operand;
                ovf_d = 1'b0;
            end
            default: begin
                res_d = operand;
                ovf_d = 1'b0;
            end
        endcase
    end

    // Data and flag are zeroed on idle stages so the output bus rests at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q  <= '0;
            data_q <= '0;
            ovf_q  <= '0;
        end else begin
            tag_q[0]  <= grant;
            data_q[0] <= (|grant) ? res_d : '0;
            ovf_q[0]  <= (|grant) ? ovf_d : 1'b0;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_q[s]  <= tag_q[s-1];
                data_q[s] <= data_q[s-1];
                ovf_q[s]  <= ovf_q[s-1];
            end
        end
    end

    assign resp_valid = tag_q[LAT-1];
    assign resp_data  = (|tag_q[LAT-1]) ? data_q[LAT-1] : '0;
    assign resp_ovf   = (|tag_q[LAT-1]) ? ovf_q[LAT-1] : 1'b0;

endmodule

// File: tb/tb_shared_resource_arb.sv
// Scoreboard bench for shared_resource_arb (2 channels, 32-bit, latency 2):
// directed vectors plus random traffic against a reference model.
module tb_shared_resource_arb;

    localparam int LAT = 2;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] data;
        logic        ovf;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_data = '0;
    logic [1:0]  op_mode = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_ovf;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    shared_resource_arb #(
        .NUM_CH(2),
        .DATA_W(32),
        .LAT   (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .op_mode   (op_mode),
        .resp_valid(resp_valid),
        .resp_data (resp_data),
        .resp_ovf  (resp_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] model_op(input logic [1:0] m, input logic [31:0] d);
        case (m)
            2'b00:   return {d[31], d << 1};
            2'b10:   return {d[31], d[31] ? 32'hFFFF_FFFF : (d << 1)};
            default: return {1'b0, d};
        endcase
    endfunction

    // Inputs change 2 time units after the falling edge, after the monitor has sampled.
    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] m, input logic [1:0] exp_rdy,
                         input logic [31:0] exp_d, input logic exp_o);
        exp_t e;
        @(negedge clk);
        #2;
        reset     = 1'b0;
        req_valid = v;
        req_data  = {d1, d0};
        op_mode   = m;
        #1;
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
        end
        if (exp_rdy != 2'b00) begin
            e.tag  = exp_rdy;
            e.data = exp_d;
            e.ovf  = exp_o;
            e.due  = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 1'b0);
    endtask

    // One reset cycle with both channels requesting; anything in flight is expected to vanish.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        req_valid = 2'b11;
        req_data  = {32'h1234_5678, 32'h9ABC_DEF0};
        op_mode   = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL ready_in_reset cyc=%0d got=%b exp=00", cyc, req_ready);
        end
        sb.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid !== 2'b00) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_resp cyc=%0d tag=%b data=%h ovf=%b exp=none",
                             cyc, resp_valid, resp_data, resp_ovf);
                end else begin
                    e = sb.pop_front();
                    if (e.due != cyc || resp_valid !== e.tag || resp_data !== e.data ||
                        resp_ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL resp cyc=%0d tag=%b data=%h ovf=%b exp cyc=%0d tag=%b data=%h ovf=%b",
                                 cyc, resp_valid, resp_data, resp_ovf, e.due, e.tag, e.data, e.ovf);
                    end
                end
            end else begin
                checks++;
                if (resp_data !== 32'h0 || resp_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_bus cyc=%0d data=%h ovf=%b exp data=0 ovf=0",
                             cyc, resp_data, resp_ovf);
                end
                while (sb.size() != 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_resp cyc=%0d got none exp tag=%b data=%h due=%0d",
                             cyc, e.tag, e.data, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout exp finish", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        logic        mp;
        logic        w;
        logic [1:0]  v;
        logic [1:0]  m;
        logic [1:0]  g;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [32:0] r;

        do_reset();

        // single channel, double
        drive(2'b01, 32'h0000_0005, 32'h0, 2'b00, 2'b01, 32'h0000_000A, 1'b0);
        idle(3);
        do_reset();

        // both channels contending from reset
        drive(2'b11, 32'h11, 32'h22, 2'b01, 2'b01, 32'h11, 1'b0);
        drive(2'b11, 32'h11, 32'h22, 2'b01, 2'b10, 32'h22, 1'b0);
        drive(2'b11, 32'h11, 32'h22, 2'b01, 2'b01, 32'h11, 1'b0);
        drive(2'b11, 32'h11, 32'h22, 2'b01, 2'b10, 32'h22, 1'b0);

        // MSB operand across all modes
        drive(2'b01, 32'h8000_0001, 32'h0, 2'b00, 2'b01, 32'h0000_0002, 1'b1);
        drive(2'b10, 32'h0, 32'h8000_0001, 2'b10, 2'b10, 32'hFFFF_FFFF, 1'b1);
        drive(2'b01, 32'h8000_0001, 32'h0, 2'b01, 2'b01, 32'h8000_0001, 1'b0);
        drive(2'b10, 32'h0, 32'h8000_0001, 2'b11, 2'b10, 32'h8000_0001, 1'b0);
        drive(2'b01, 32'h4000_0003, 32'h0, 2'b10, 2'b01, 32'h8000_0006, 1'b0);

        // pointer holds across idle; lone ch0 granted right away
        drive(2'b10, 32'h0, 32'h7, 2'b01, 2'b10, 32'h7, 1'b0);
        idle(2);
        drive(2'b01, 32'h9, 32'h0, 2'b00, 2'b01, 32'h12, 1'b0);
        idle(1);
        drive(2'b11, 32'h3, 32'h4, 2'b01, 2'b10, 32'h4, 1'b0);
        drive(2'b11, 32'h3, 32'h4, 2'b00, 2'b01, 32'h6, 1'b0);

        // reset one cycle after a grant discards it and rewinds the pointer
        idle(2);
        drive(2'b01, 32'h55, 32'h0, 2'b01, 2'b01, 32'h55, 1'b0);
        do_reset();
        idle(3);
        drive(2'b11, 32'h1, 32'h2, 2'b00, 2'b01, 32'h2, 1'b0);

        // random traffic against the reference model
        idle(2);
        do_reset();
        mp = 1'b0;
        for (int n = 0; n < 300; n++) begin
            v  = 2'($urandom_range(0, 3));
            m  = 2'($urandom_range(0, 3));
            d0 = $urandom;
            d1 = $urandom;
            g  = 2'b00;
            r  = '0;
            if (v != 2'b00) begin
                w  = v[mp] ? mp : ~mp;
                g  = w ? 2'b10 : 2'b01;
                mp = ~w;
                r  = model_op(m, w ? d1 : d0);
            end
            drive(v, d0, d1, m, g, r[31:0], r[32]);
        end

        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_resource_arb.md
SHARED_RESOURCE_ARB -- requirements
Module: shared_resource_arb

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, operand/result width (8..64).
REQ-003 SHALL have parameter LAT, default 2, grant-to-response latency in cycles (1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_CH  per-channel request valid.
REQ-007 SHALL have port req_ready  output  NUM_CH  per-channel grant, one-hot or zero.
REQ-008 SHALL have port req_data  input  NUM_CH*DATA_W  operands; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port op_mode  input  2  operation applied to the operand granted in the same cycle.
REQ-010 SHALL have port resp_valid  output  NUM_CH  one-hot tag of the channel owning resp_data, or zero.
REQ-011 SHALL have port resp_data  output  DATA_W  shared result bus.
REQ-012 SHALL have port resp_ovf  output  1  result overflow flag, qualified by |resp_valid.

Function
REQ-013 SHALL grant at most one channel per cycle; req_ready[i] SHALL be high only when req_valid[i] is high; the transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-014 SHALL arbitrate round-robin: search starts at rr_ptr and wraps from NUM_CH-1 to 0; the first valid channel found wins.
REQ-015 SHALL load rr_ptr with (granted index + 1) mod NUM_CH on a grant; rr_ptr SHALL hold when no channel is granted.
REQ-016 SHALL compute the result at grant time. op_mode 00: operand<<1, truncated to DATA_W. 01: pass-through. 10: saturating double, all-ones when operand MSB is 1. 11: pass-through (reserved).
REQ-017 SHALL set ovf to operand MSB for modes 00 and 10, and to 0 for modes 01 and 11.
REQ-018 SHALL carry {result, ovf, one-hot tag} through a LAT-stage valid pipeline with no stall.
REQ-019 SHALL present a request granted in cycle t on resp_valid/resp_data/resp_ovf in cycle t+LAT, for exactly one cycle.
REQ-020 SHALL accept one request per cycle in steady state; back-to-back grants SHALL produce back-to-back responses.
REQ-021 SHALL drive resp_data and resp_ovf to 0 whenever resp_valid is zero.
REQ-022 SHALL not let a dropped req_valid withdraw an earlier, already-granted request.

Reset
REQ-023 SHALL, in any cycle with reset high, clear rr_ptr to 0 and all pipeline valids, data and ovf to 0.
REQ-024 SHALL hold req_ready at 0 while reset is high.
REQ-025 SHALL discard in-flight requests on reset mid-operation; no response for them appears after reset deasserts.
REQ-026 SHALL produce the first grant in the cycle after reset deasserts, when any req_valid is high.

Structure
REQ-027 SHALL place op_mode encodings (OP_DBL, OP_PASS, OP_SAT, OP_RSVD) and the parameter limits in package shared_resource_pkg.
REQ-028 SHALL implement arbitration in sub-module rr_arbiter (parameter N; ports req, grant, ptr update); the datapath and pipeline SHALL live in the top module.

Verification (NUM_CH=2, DATA_W=32, LAT=2)
REQ-029 SHALL cover: ch0 only, operand 0x0000_0005, mode 00 in cycle t -> resp_valid=01, resp_data=0x0000_000A, resp_ovf=0 in cycle t+2.
REQ-030 SHALL cover: both channels valid for 4 cycles after reset -> grants 0,1,0,1; responses tagged 01,10,01,10 on consecutive cycles.
REQ-031 SHALL cover: operand 0x8000_0001, mode 00 -> 0x0000_0002, ovf=1; mode 10 -> 0xFFFF_FFFF, ovf=1; mode 01 -> 0x8000_0001, ovf=0.
REQ-032 SHALL cover: reset asserted one cycle after a grant -> no resp_valid for 3 cycles after reset deasserts while inputs are idle; rr_ptr=0, so with both channels valid ch0 is granted first.
REQ-033 SHALL cover: ch1 granted, ch1 then idle, ch0 alone valid -> ch0 granted immediately with no idle cycle; rr_ptr holds across idle cycles.
REQ-034 SHALL cover: a random-traffic scoreboard confirming every accepted request yields exactly one response with the correct tag and value after exactly LAT cycles.
